// File: rtl/timekeeper_pkg.sv
// Shared constants, time-bus layout and field helpers for the timekeeper blocks.
package timekeeper_pkg;

    localparam int MODE_CLOCK     = 0;
    localparam int MODE_STOPWATCH = 1;
    localparam int MODE_COUNTDOWN = 2;

    localparam logic [1:0] FLD_SEC  = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_HOUR = 2'd2;
    localparam logic [1:0] FLD_NONE = 2'd3;

    localparam int MSEC_MOD = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;

    localparam int TIME_W   = 25;
    localparam int MSEC_LSB = 0;
    localparam int MSEC_MSB = 6;
    localparam int SEC_LSB  = 7;
    localparam int SEC_MSB  = 12;
    localparam int MIN_LSB  = 13;
    localparam int MIN_MSB  = 18;
    localparam int HOUR_LSB = 19;
    localparam int HOUR_MSB = 24;

    // Field order matches the display bus {hour,min,sec,msec}.
    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] msec;
    } time_t;

    // Wrap a single field by +/-1 within 0..max_v, no carry out.
    function automatic logic [5:0] field_adjust(input logic [5:0] v,
                                                input logic [5:0] max_v,
                                                input logic       up);
        if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? max_v : v - 6'd1;
    endfunction

endpackage

// File: rtl/timekeeper_core_tick_divider.sv
// Clock divider producing a one-cycle tick every DIV enabled cycles.
module tick_divider #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Tick is combinational so the consumer can register it with its own update.
    assign tick = enable && !clear && (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/timekeeper_core.sv
// msec/sec/min/hour counter chain whose personality (clock, stopwatch, countdown) is fixed by MODE.
module timekeeper_core
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MODE      = 0,
    parameter int HOUR_MOD  = 24,
    parameter int INIT_HOUR = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        stop,
    input  logic        clear,
    input  logic        set_en,
    input  logic [1:0]  field_sel,
    input  logic        inc,
    input  logic        dec,
    output logic [24:0] time_out,
    output logic        running,
    output logic        tick_out,
    output logic        expired
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam bit IS_CLOCK = (MODE == MODE_CLOCK);
    localparam bit IS_CD    = (MODE == MODE_COUNTDOWN);

    localparam logic [6:0] MSEC_MAX = 7'(MSEC_MOD - 1);
    localparam logic [5:0] SEC_MAX  = 6'(SEC_MOD - 1);
    localparam logic [5:0] MIN_MAX  = 6'(MIN_MOD - 1);
    localparam logic [5:0] HOUR_MAX = 6'(HOUR_MOD - 1);

    localparam time_t RESET_TIME = {(IS_CLOCK ? 6'(INIT_HOUR) : 6'd0), 6'd0, 6'd0, 7'd0};

    time_t cur;
    time_t tick_next;
    time_t adj_next;
    logic  tick;
    logic  advancing;
    logic  is_zero;
    logic  adjust_ok;

    // The clock personality freezes while the user is setting it.
    assign advancing = running && !(IS_CLOCK && set_en);
    assign is_zero   = (cur == '0);
    assign time_out  = cur;

    tick_divider #(.DIV(TICK_DIV)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (advancing),
        .clear   (clear),
        .tick    (tick)
    );

    generate
        if (MODE == MODE_COUNTDOWN) begin : g_down
            always_comb begin
                tick_next = cur;
                if (cur.msec != 7'd0) begin
                    tick_next.msec = cur.msec - 7'd1;
                end else begin
                    tick_next.msec = MSEC_MAX;
                    if (cur.sec != 6'd0) begin
                        tick_next.sec = cur.sec - 6'd1;
                    end else begin
                        tick_next.sec = SEC_MAX;
                        if (cur.min != 6'd0) begin
                            tick_next.min = cur.min - 6'd1;
                        end else begin
                            tick_next.min  = MIN_MAX;
                            tick_next.hour = cur.hour - 6'd1;
                        end
                    end
                end
            end
        end else begin : g_up
            always_comb begin
                tick_next = cur;
                if (cur.msec != MSEC_MAX) begin
                    tick_next.msec = cur.msec + 7'd1;
                end else begin
                    tick_next.msec = '0;
                    if (cur.sec != SEC_MAX) begin
                        tick_next.sec = cur.sec + 6'd1;
                    end else begin
                        tick_next.sec = '0;
                        if (cur.min != MIN_MAX) begin
                            tick_next.min = cur.min + 6'd1;
                        end else begin
                            tick_next.min  = '0;
                            tick_next.hour = (cur.hour == HOUR_MAX) ? 6'd0 : cur.hour + 6'd1;
                        end
                    end
                end
            end
        end
    endgenerate

    assign adjust_ok = set_en && (field_sel != FLD_NONE) && (inc ^ dec)
                       && (IS_CLOCK || (IS_CD && !running));

    always_comb begin
        adj_next = cur;
        case (field_sel)
            FLD_SEC:  adj_next.sec  = field_adjust(cur.sec, SEC_MAX, inc);
            FLD_MIN:  adj_next.min  = field_adjust(cur.min, MIN_MAX, inc);
            FLD_HOUR: adj_next.hour = field_adjust(cur.hour, HOUR_MAX, inc);
            default:  adj_next = cur;
        endcase
    end

    // A countdown tick at zero is the expiry event: value holds, counting stops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= RESET_TIME;
            running  <= IS_CLOCK;
            tick_out <= 1'b0;
            expired  <= 1'b0;
        end else begin
            tick_out <= tick;
            expired  <= IS_CD && tick && is_zero;
            if (clear) begin
                cur     <= RESET_TIME;
                running <= IS_CLOCK;
            end else begin
                if (tick) begin
                    if (!(IS_CD && is_zero)) cur <= tick_next;
                end else if (adjust_ok) begin
                    cur <= adj_next;
                end
                if (!IS_CLOCK) begin
                    if (stop)                          running <= 1'b0;
                    else if (IS_CD && tick && is_zero) running <= 1'b0;
                    else if (run && !(IS_CD && is_zero)) running <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench: one instance per personality, driven from shared controls.
module tb_timekeeper_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        set_en = 1'b0;
    logic [1:0]  field_sel = 2'd3;
    logic        inc = 1'b0;
    logic        dec = 1'b0;

    logic [24:0] sw_time, ck_time, cd_time;
    logic        sw_running, ck_running, cd_running;
    logic        sw_tick, ck_tick, cd_tick;
    logic        sw_expired, ck_expired, cd_expired;

    int errors = 0;
    int checks = 0;
    int sw_ticks = 0;
    int ck_ticks = 0;
    int snap;

    always #5 clk = ~clk;

    always @(posedge sw_tick) sw_ticks++;
    always @(posedge ck_tick) ck_ticks++;

    timekeeper_core #(.CLK_HZ(1000), .TICK_HZ(100), .MODE(1)) dut_sw (
        .clk(clk), .reset_n(reset_n), .run(run), .stop(stop), .clear(clear),
        .set_en(set_en), .field_sel(field_sel), .inc(inc), .dec(dec),
        .time_out(sw_time), .running(sw_running), .tick_out(sw_tick), .expired(sw_expired));

    timekeeper_core #(.CLK_HZ(1000), .TICK_HZ(100), .MODE(0)) dut_ck (
        .clk(clk), .reset_n(reset_n), .run(run), .stop(stop), .clear(clear),
        .set_en(set_en), .field_sel(field_sel), .inc(inc), .dec(dec),
        .time_out(ck_time), .running(ck_running), .tick_out(ck_tick), .expired(ck_expired));

    timekeeper_core #(.CLK_HZ(1000), .TICK_HZ(100), .MODE(2)) dut_cd (
        .clk(clk), .reset_n(reset_n), .run(run), .stop(stop), .clear(clear),
        .set_en(set_en), .field_sel(field_sel), .inc(inc), .dec(dec),
        .time_out(cd_time), .running(cd_running), .tick_out(cd_tick), .expired(cd_expired));

    function automatic logic [24:0] tv(input int h, input int m, input int s, input int ms);
        return {6'(h), 6'(m), 6'(s), 7'(ms)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic pulse_run();  run = 1'b1;  cyc(1); run = 1'b0;  endtask
    task automatic pulse_stop(); stop = 1'b1; cyc(1); stop = 1'b0; endtask
    task automatic pulse_inc();  inc = 1'b1;  cyc(1); inc = 1'b0;  endtask
    task automatic pulse_dec();  dec = 1'b1;  cyc(1); dec = 1'b0;  endtask

    initial begin
        // Stopwatch: reset values of all personalities
        cyc(2);
        check("sw_reset_time", sw_time, 0);
        check("sw_reset_running", sw_running, 0);
        check("sw_reset_tick", sw_tick, 0);
        check("sw_reset_expired", sw_expired, 0);
        check("ck_reset_time", ck_time, tv(12, 0, 0, 0));
        check("ck_reset_running", ck_running, 1);
        check("cd_reset_time", cd_time, 0);
        reset_n = 1'b1;
        cyc(1);

        pulse_run();
        snap = sw_ticks;
        cyc(1000);
        check("sw_1s_time", sw_time, tv(0, 0, 1, 0));
        check("sw_1s_ticks", sw_ticks - snap, 100);
        check("sw_1s_tick_out", sw_tick, 1);
        pulse_stop();
        cyc(50);
        check("sw_frozen_time", sw_time, tv(0, 0, 1, 0));
        check("sw_frozen_running", sw_running, 0);
        set_en = 1'b1; field_sel = 2'd0;
        pulse_inc();
        set_en = 1'b0; field_sel = 2'd3;
        check("sw_inc_ignored", sw_time, tv(0, 0, 1, 0));
        run = 1'b1; stop = 1'b1;
        cyc(1);
        run = 1'b0; stop = 1'b0;
        check("sw_run_stop_same", sw_running, 0);

        // Stopwatch: asynchronous reset mid-count
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        pulse_run();
        cyc(5370);
        check("sw_5_37", sw_time, tv(0, 0, 5, 37));
        reset_n = 1'b0;
        #2;
        check("async_sw_time", sw_time, 0);
        check("async_sw_running", sw_running, 0);
        check("async_ck_time", ck_time, tv(12, 0, 0, 0));
        check("async_ck_running", ck_running, 1);
        #2;
        reset_n = 1'b1;
        cyc(30);
        check("after_rst_idle_time", sw_time, 0);
        check("after_rst_idle_running", sw_running, 0);
        pulse_run();
        cyc(10);
        check("after_rst_first_tick", sw_time, tv(0, 0, 0, 1));
        check("after_rst_tick_out", sw_tick, 1);

        // Clock: adjust to 23:59:59 then roll over
        reset_n = 1'b0; set_en = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        check("ck_reset2_time", ck_time, tv(12, 0, 0, 0));
        field_sel = 2'd0; pulse_dec();
        field_sel = 2'd1; pulse_dec();
        field_sel = 2'd2;
        for (int i = 0; i < 11; i++) pulse_inc();
        field_sel = 2'd3;
        check("ck_set_235959", ck_time, tv(23, 59, 59, 0));
        snap = ck_ticks;
        cyc(200);
        check("ck_set_freeze_time", ck_time, tv(23, 59, 59, 0));
        check("ck_set_freeze_ticks", ck_ticks - snap, 0);
        set_en = 1'b0;
        cyc(999);
        check("ck_pre_roll", ck_time, tv(23, 59, 59, 99));
        cyc(1);
        check("ck_rollover", ck_time, tv(0, 0, 0, 0));
        check("ck_running", ck_running, 1);

        // Clock: field wrap adjustments
        set_en = 1'b1; field_sel = 2'd0;
        pulse_dec();
        check("ck_sec_dec_wrap", ck_time, tv(0, 0, 59, 0));
        pulse_inc();
        check("ck_sec_inc_wrap", ck_time, tv(0, 0, 0, 0));
        field_sel = 2'd2;
        pulse_dec();
        check("ck_hour_dec_wrap", ck_time, tv(23, 0, 0, 0));
        inc = 1'b1; dec = 1'b1;
        cyc(1);
        inc = 1'b0; dec = 1'b0;
        check("ck_inc_dec_same", ck_time, tv(23, 0, 0, 0));
        field_sel = 2'd3;
        pulse_inc();
        check("ck_field_none", ck_time, tv(23, 0, 0, 0));
        pulse_stop();
        check("ck_stop_ignored", ck_running, 1);

        // Clock: clear beats run and a due tick; divider restarts
        set_en = 1'b0;
        cyc(9);
        check("ck_before_clear", ck_time, tv(23, 0, 0, 0));
        clear = 1'b1; run = 1'b1; inc = 1'b1;
        cyc(1);
        clear = 1'b0; run = 1'b0; inc = 1'b0;
        check("ck_clear_time", ck_time, tv(12, 0, 0, 0));
        check("ck_clear_running", ck_running, 1);
        check("ck_clear_no_tick", ck_tick, 0);
        cyc(9);
        check("ck_clear_wait9", ck_time, tv(12, 0, 0, 0));
        cyc(1);
        check("ck_clear_first_tick", ck_time, tv(12, 0, 0, 1));
        check("ck_clear_tick_out", ck_tick, 1);
        set_en = 1'b1; field_sel = 2'd0; clear = 1'b1; inc = 1'b1;
        cyc(1);
        clear = 1'b0; inc = 1'b0; set_en = 1'b0; field_sel = 2'd3;
        check("ck_clear_over_inc", ck_time, tv(12, 0, 0, 0));

        // Countdown: 2 s to expiry
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        check("cd_reset_time2", cd_time, 0);
        check("cd_reset_running", cd_running, 0);
        set_en = 1'b1; field_sel = 2'd0;
        pulse_inc();
        pulse_inc();
        set_en = 1'b0; field_sel = 2'd3;
        check("cd_set_2s", cd_time, tv(0, 0, 2, 0));
        pulse_run();
        check("cd_running", cd_running, 1);
        cyc(500);
        set_en = 1'b1; field_sel = 2'd0;
        pulse_inc();
        set_en = 1'b0; field_sel = 2'd3;
        check("cd_inc_while_running", cd_time, tv(0, 0, 1, 50));
        cyc(1499);
        check("cd_at_zero", cd_time, 0);
        check("cd_at_zero_running", cd_running, 1);
        check("cd_at_zero_expired", cd_expired, 0);
        cyc(9);
        check("cd_pre_expiry", cd_expired, 0);
        cyc(1);
        check("cd_expired", cd_expired, 1);
        check("cd_expired_running", cd_running, 0);
        check("cd_expired_time", cd_time, 0);
        cyc(1);
        check("cd_expired_one_cycle", cd_expired, 0);
        pulse_run();
        check("cd_run_at_zero", cd_running, 0);
        cyc(20);
        check("cd_idle_time", cd_time, 0);
        check("cd_idle_expired", cd_expired, 0);
        check("sw_never_expires", sw_expired, 0);
        check("ck_never_expires", ck_expired, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
